// File: rtl/control_pkg.sv
// Shared types and select encodings for the multi-cycle control sequencer
// and the datapath multiplexers it drives.
package control_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALTED    = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_ADDI  = 4'd2,
    OP_LOAD  = 4'd3,
    OP_STORE = 4'd4,
    OP_JUMP  = 4'd5,
    OP_BEQ   = 4'd6,
    OP_HALT  = 4'd15
  } opcode_t;

  localparam logic [1:0] PC_SEL_INC    = 2'd0;
  localparam logic [1:0] PC_SEL_JUMP   = 2'd1;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd2;
  localparam logic [1:0] ALU_B_REG     = 2'd0;
  localparam logic [1:0] ALU_B_IMM     = 2'd1;
  localparam logic [1:0] WB_ALU        = 2'd0;
  localparam logic [1:0] WB_MEM        = 2'd1;

  function automatic logic op_is_legal(input logic [3:0] op);
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd15: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Fetch-stage valid/ready opcode handshake between the fetch stage (master)
// and the control sequencer (slave).
interface control_unit_if #(
  parameter int OPCODE_WIDTH = 4
);
  logic                    instr_valid;
  logic                    instr_ready;
  logic [OPCODE_WIDTH-1:0] opcode;

  modport master (output instr_valid, output opcode, input instr_ready);
  modport slave  (input instr_valid, input opcode, output instr_ready);
endinterface

// File: rtl/control_unit_perf_counter.sv
// Free-running 32-bit performance counter with count enable and freeze;
// wraps from all-ones to zero.
module perf_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic        freeze_i,
  output logic [31:0] count_o
);
  logic [31:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 32'd0;
    end else if (en_i && !freeze_i) begin
      count_q <= count_q + 32'd1;
    end else begin
      count_q <= count_q;
    end
  end

  assign count_o = count_q;
endmodule

// File: rtl/control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer driving the datapath
// mux selects and write strobes. Define CONTROL_UNIT_PERF_EN for the perf counters.
module control_unit
  import control_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4,
  parameter int SEL_WIDTH    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  control_unit_if.slave        fetch,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic [SEL_WIDTH-1:0] pc_sel,
  output logic [SEL_WIDTH-1:0] alu_b_sel,
  output logic [SEL_WIDTH-1:0] wb_sel,
  output logic                 reg_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 pc_write,
  output logic                 halted,
  output logic                 illegal,
  output logic [31:0]          cycle_count,
  output logic [31:0]          instr_count
);
  state_t                  state_q;
  logic [OPCODE_WIDTH-1:0] ir_q;
  logic                    illegal_q;

  logic       legal_s, op_nop_s, op_addi_s, op_load_s, op_store_s;
  logic       op_jump_s, op_beq_s, op_halt_s, is_imm_s;
  logic       instr_ready_s, reg_write_s, mem_read_s, mem_write_s, pc_write_s;
  logic [1:0] pc_sel_s, alu_b_sel_s, wb_sel_s;

  // Opcodes wider than 4 bits are legal only when the upper bits are zero.
  assign legal_s    = ((ir_q >> 4) == '0) && op_is_legal(ir_q[3:0]);
  assign op_nop_s   = (ir_q == OPCODE_WIDTH'(OP_NOP));
  assign op_addi_s  = (ir_q == OPCODE_WIDTH'(OP_ADDI));
  assign op_load_s  = (ir_q == OPCODE_WIDTH'(OP_LOAD));
  assign op_store_s = (ir_q == OPCODE_WIDTH'(OP_STORE));
  assign op_jump_s  = (ir_q == OPCODE_WIDTH'(OP_JUMP));
  assign op_beq_s   = (ir_q == OPCODE_WIDTH'(OP_BEQ));
  assign op_halt_s  = (ir_q == OPCODE_WIDTH'(OP_HALT));
  assign is_imm_s   = op_addi_s | op_load_s | op_store_s;

  // Sequencer state, instruction register and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (fetch.instr_valid) begin
            ir_q    <= fetch.opcode;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (op_halt_s || !legal_s) begin
            state_q   <= S_HALTED;
            illegal_q <= !legal_s;
          end else begin
            state_q <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          if (op_load_s || op_store_s)             state_q <= S_MEM;
          else if (op_nop_s || op_jump_s || op_beq_s) state_q <= S_FETCH;
          else                                     state_q <= S_WRITEBACK;
        end
        S_MEM: begin
          if (mem_ready) state_q <= op_load_s ? S_WRITEBACK : S_FETCH;
        end
        S_WRITEBACK: state_q <= S_FETCH;
        S_HALTED:    state_q <= S_HALTED;
        default:     state_q <= S_FETCH;
      endcase
    end
  end

  // Output decode; only BEQ's branch select and STORE's completing PC write see live inputs.
  always_comb begin
    instr_ready_s = 1'b0;
    pc_sel_s      = PC_SEL_INC;
    alu_b_sel_s   = ALU_B_REG;
    wb_sel_s      = WB_ALU;
    reg_write_s   = 1'b0;
    mem_read_s    = 1'b0;
    mem_write_s   = 1'b0;
    pc_write_s    = 1'b0;
    case (state_q)
      S_FETCH: instr_ready_s = 1'b1;
      S_EXECUTE: begin
        alu_b_sel_s = is_imm_s ? ALU_B_IMM : ALU_B_REG;
        if (op_jump_s) begin
          pc_write_s = 1'b1;
          pc_sel_s   = PC_SEL_JUMP;
        end else if (op_beq_s) begin
          pc_write_s = 1'b1;
          pc_sel_s   = zero ? PC_SEL_BRANCH : PC_SEL_INC;
        end else if (op_nop_s) begin
          pc_write_s = 1'b1;
        end else begin
          pc_write_s = 1'b0;
        end
      end
      S_MEM: begin
        mem_read_s  = op_load_s;
        mem_write_s = op_store_s;
        pc_write_s  = op_store_s & mem_ready;
      end
      S_WRITEBACK: begin
        reg_write_s = 1'b1;
        pc_write_s  = 1'b1;
        wb_sel_s    = op_load_s ? WB_MEM : WB_ALU;
      end
      default: instr_ready_s = 1'b0;
    endcase
  end

  assign fetch.instr_ready = instr_ready_s;
  assign pc_sel            = SEL_WIDTH'(pc_sel_s);
  assign alu_b_sel         = SEL_WIDTH'(alu_b_sel_s);
  assign wb_sel            = SEL_WIDTH'(wb_sel_s);
  assign reg_write         = reg_write_s;
  assign mem_read          = mem_read_s;
  assign mem_write         = mem_write_s;
  assign pc_write          = pc_write_s;
  assign halted            = (state_q == S_HALTED);
  assign illegal           = illegal_q;

`ifdef CONTROL_UNIT_PERF_EN
  logic halted_prev_q;

  // Freeze lags halted by one cycle so the first HALTED cycle is still counted.
  always_ff @(posedge clk) begin
    if (reset) halted_prev_q <= 1'b0;
    else       halted_prev_q <= halted;
  end

  perf_counter u_cycle_count (
    .clk      (clk),
    .reset    (reset),
    .en_i     (1'b1),
    .freeze_i (halted_prev_q),
    .count_o  (cycle_count)
  );

  perf_counter u_instr_count (
    .clk      (clk),
    .reset    (reset),
    .en_i     (pc_write_s),
    .freeze_i (halted_prev_q),
    .count_o  (instr_count)
  );
`else
  assign cycle_count = 32'd0;
  assign instr_count = 32'd0;
`endif

endmodule
